// File: rtl/dro_bank_sequencer.sv
// ============================================================================
// Module   : dro_bank_sequencer
// Brief    : Two-port round-robin command sequencer driving a bank of DRO cells
//            by set/reset toggles; returns read data from output-line toggles.
//            Optional shadow consistency checker: DRO_SEQ_SHADOW_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dro_bank_sequencer #(
    parameter int CELLS   = 4,
    parameter int AW      = 2,
    parameter int GAP     = 2,
    parameter int RD_WAIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_op,
    input  logic [AW-1:0]    a_addr,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_op,
    input  logic [AW-1:0]    b_addr,
    output logic             rsp_valid,
    output logic             rsp_src,
    output logic             rsp_data,
    output logic [CELLS-1:0] set_o,
    output logic [CELLS-1:0] reset_o,
    input  logic [CELLS-1:0] out_i,
    output logic             err_o
);

    localparam int CNT_MAX = (GAP > RD_WAIT) ? GAP : RD_WAIT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GAP_WAIT  = 2'd1,
        RD_WAIT_S = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic             src_q, src_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CELLS-1:0] set_q, set_d;
    logic [CELLS-1:0] rsto_q, rsto_d;
    logic [CELLS-1:0] out_ref_q, out_ref_d;
    logic             rsp_data_q, rsp_data_d;

    logic             w_idle, w_grant_a, w_grant_b, w_hs, w_sample, w_rd_bit;
    logic             w_in_op;
    logic [AW-1:0]    w_in_addr;
    logic [CELLS-1:0] w_sel_in, w_sel_q;

    // A wins unless B is also valid and A was the last one served.
    assign w_idle    = (state_q == IDLE);
    assign w_grant_a = a_valid && (!b_valid || last_b_q);
    assign w_grant_b = b_valid && !w_grant_a;
    assign w_hs      = w_idle && (a_valid || b_valid);
    assign w_in_op   = w_grant_a ? a_op   : b_op;
    assign w_in_addr = w_grant_a ? a_addr : b_addr;

    assign a_ready   = w_idle && w_grant_a && !reset;
    assign b_ready   = w_idle && w_grant_b && !reset;

    // One-hot decodes; addresses beyond CELLS decode to all-zero (no pulse).
    for (genvar c = 0; c < CELLS; c++) begin : g_sel
        assign w_sel_in[c] = (w_in_addr == AW'(c));
        assign w_sel_q[c]  = (addr_q    == AW'(c));
    end

    assign w_sample = (state_q == RD_WAIT_S) && (cnt_q == '0);
    assign w_rd_bit = |((out_i ^ out_ref_q) & w_sel_q);

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        src_d      = src_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        set_d      = set_q;
        rsto_d     = rsto_q;
        out_ref_d  = out_ref_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                out_ref_d = out_i;
                if (w_hs) begin
                    last_b_d = !w_grant_a;
                    src_d    = !w_grant_a;
                    addr_d   = w_in_addr;
                    if (!w_in_op) begin
                        set_d   = set_q ^ w_sel_in;
                        cnt_d   = CW'(GAP - 1);
                        state_d = GAP_WAIT;
                    end else begin
                        rsto_d  = rsto_q ^ w_sel_in;
                        cnt_d   = CW'(RD_WAIT - 1);
                        state_d = RD_WAIT_S;
                    end
                end
            end
            GAP_WAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            RD_WAIT_S: begin
                if (w_sample) begin
                    rsp_data_d = w_rd_bit;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            src_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            set_q      <= '0;
            rsto_q     <= '0;
            out_ref_q  <= '0;
            rsp_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            set_q      <= set_d;
            rsto_q     <= rsto_d;
            out_ref_q  <= out_ref_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign set_o     = set_q;
    assign reset_o   = rsto_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_src   = src_q;
    assign rsp_data  = rsp_data_q;

`ifdef DRO_SEQ_SHADOW_CHECK_EN
    logic [CELLS-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
    logic             idle_seen_q;

    // Shadow clears at sample time so the read compares against the pre-read value.
    // Stray detection skips the first IDLE cycle, where out_ref still holds the pre-read level.
    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        if (w_hs && !w_in_op) shadow_d = shadow_q | w_sel_in;
        if (w_sample) begin
            shadow_d = shadow_q & ~w_sel_q;
            if (w_rd_bit != |(shadow_q & w_sel_q)) err_d = 1'b1;
        end
        if (w_idle && idle_seen_q && (out_i != out_ref_q)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            err_q       <= 1'b0;
            idle_seen_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            err_q       <= err_d;
            idle_seen_q <= w_idle;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dro_bank_sequencer.sv
// ============================================================================
// Module   : tb_dro_bank_sequencer
// Brief    : Directed self-checking bench for dro_bank_sequencer with a
//            behavioural DRO cell model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dro_bank_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, a_op, b_valid, b_op;
    logic [1:0] a_addr, b_addr;
    logic       a_ready, b_ready, rsp_valid, rsp_src, rsp_data, err_o;
    logic [3:0] set_o, reset_o, out_i;

    logic [3:0] out_model, stray, stored, prev_set, prev_rst;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DRO_SEQ_SHADOW_CHECK_EN
    localparam logic STRAY_ERR = 1'b1;
`else
    localparam logic STRAY_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    dro_bank_sequencer #(.CELLS(4), .AW(2), .GAP(2), .RD_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_addr(a_addr),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_addr(b_addr),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data),
        .set_o(set_o), .reset_o(reset_o), .out_i(out_i), .err_o(err_o)
    );

    // DRO cell: a set toggle stores a 1; a reset toggle on a stored cell pulses out one cycle later.
    assign out_i = out_model ^ stray;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            out_model <= '0;
            stored    <= '0;
            prev_set  <= '0;
            prev_rst  <= '0;
        end else begin
            stored    <= (stored | (set_o ^ prev_set)) & ~(reset_o ^ prev_rst);
            out_model <= out_model ^ ((reset_o ^ prev_rst) & stored);
            prev_set  <= set_o;
            prev_rst  <= reset_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int   n_grant;
    logic grant_b [4];

    initial begin
        reset = 1'b1; stray = '0;
        a_valid = 0; a_op = 0; a_addr = 0;
        b_valid = 0; b_op = 0; b_addr = 0;
        step(); step();
        chk("rst_ready",  {30'd0, a_ready, b_ready}, 0);
        chk("rst_rsp",    {29'd0, rsp_valid, rsp_src, rsp_data}, 0);
        chk("rst_lines",  {24'd0, set_o, reset_o}, 0);
        chk("rst_err",    err_o, 0);
        @(negedge clk); reset = 1'b0;

        // Write cell 1 then read it back from port A
        step(); a_valid = 1; a_op = 0; a_addr = 2'd1; #1;
        chk("wr_accept", {a_ready, b_ready}, 2'b10);
        step(); a_op = 1; #1;
        chk("wr_set_o", set_o, 4'b0010);
        chk("gap1_ready", a_ready, 0);
        step();
        chk("gap2_ready", a_ready, 0);
        step();
        chk("rd_accept", a_ready, 1);
        step(); a_valid = 0; #1;
        chk("rd_reset_o", reset_o, 4'b0010);
        step(); step();
        chk("rd_no_rsp_yet", rsp_valid, 0);
        step();
        chk("rd1_rsp", {rsp_valid, rsp_src, rsp_data}, 3'b101);

        // Read cell 2 never written
        step(); a_valid = 1; a_op = 1; a_addr = 2'd2; #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("rd2_accept", a_ready, 1);
        step(); a_valid = 0; #1;
        chk("rd2_reset_o", reset_o, 4'b0110);
        step(); step(); step();
        chk("rd2_rsp", {rsp_valid, rsp_src, rsp_data}, 3'b100);
        chk("rd2_err", err_o, 0);

        // Stray output pulse while idle
        step(); step(); step();
        chk("pre_stray_err", err_o, 0);
        stray = 4'b0001;
        step();
        chk("stray_err", err_o, STRAY_ERR);
        step(); step();
        chk("stray_err_sticky", err_o, STRAY_ERR);

        // Reset in the middle of a read wait
        step(); a_valid = 1; a_op = 1; a_addr = 2'd1; #1;
        chk("rd3_accept", a_ready, 1);
        step(); a_valid = 0; #1;
        chk("rd3_reset_o", reset_o, 4'b0100);
        step(); reset = 1'b1; stray = '0; #1;
        chk("midrst_lines", {24'd0, set_o, reset_o}, 0);
        chk("midrst_out", {rsp_valid, rsp_src, rsp_data, err_o}, 0);
        step();
        chk("midrst_hold", rsp_valid, 0);

        // Release with both ports valid: A first, then strict alternation
        @(negedge clk);
        reset = 1'b0;
        a_valid = 1; a_op = 0; a_addr = 2'd0;
        b_valid = 1; b_op = 0; b_addr = 2'd3;
        #1;
        chk("release_accept", a_ready, 1);
        n_grant = 0;
        for (int i = 0; i < 40 && n_grant < 4; i++) begin
            if (i > 0) step();
            if (rsp_valid) chk("arb_no_rsp", rsp_valid, 0);
            if (a_ready || b_ready) begin
                grant_b[n_grant] = b_ready;
                n_grant++;
            end
        end
        chk("arb_grants", n_grant, 4);
        if (n_grant == 4) begin
            chk("arb_g0_A", grant_b[0], 0);
            chk("arb_g1_B", grant_b[1], 1);
            chk("arb_g2_A", grant_b[2], 0);
            chk("arb_g3_B", grant_b[3], 1);
        end
        step(); a_valid = 0; b_valid = 0; #1;
        chk("arb_set_o", set_o, 4'b0000);
        chk("arb_err", err_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dro_bank_sequencer.md
# dro_bank_sequencer

Clocked command sequencer that shares a bank of destructive-readout (DRO) cells between two requester ports. It uses a round-robin arbiter and converts each accepted write or read command into a single toggle on the target cell's set or reset line. It enforces spacing between pulses to the same bank so the DRO hold windows are never violated, and it returns read data by detecting a toggle on the cell's output line. It sits between the digital test-harness logic and the behavioural DRO cell models.

## Interface
- CELLS, 4, number of DRO cells driven
- AW, 2, address width; CELLS ≤ 2^AW
- GAP, 2, idle cycles after a write pulse before the next command is accepted (≥1)
- RD_WAIT, 3, cycles between a reset toggle and sampling the cell output (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- a_valid  in  1  port A command valid
- a_ready  out  1  port A command accepted this cycle when a_valid && a_ready
- a_op  in  1  0 = write (set cell), 1 = read (reset cell, return data)
- a_addr  in  AW  target cell
- b_valid, b_ready, b_op, b_addr: port B, same widths and meaning as port A
- rsp_valid  out  1  one-cycle read-response strobe
- rsp_src  out  1  0 = port A, 1 = port B
- rsp_data  out  1  read result
- set_o  out  CELLS  per-cell set line; each pulse is one level toggle
- reset_o  out  CELLS  per-cell reset line; each pulse is one level toggle
- out_i  in  CELLS  per-cell DRO output; each toggle is one output pulse
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
- FSM states: IDLE, GAP_WAIT, RD_WAIT_S, RESP.
- In IDLE, a_ready or b_ready is high for the granted port only, and only when that port's valid is high.
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last time wins.
  - last_grant resets to B, so A wins the first contention.
- In IDLE, out_ref[CELLS] is loaded from out_i every cycle. It is frozen in all other states.
- On handshake, the selected op and addr are registered.
- Write command:
  - set_o[addr] toggles.
  - FSM goes to GAP_WAIT for GAP cycles, then returns to IDLE.
- Read command:
  - reset_o[addr] toggles.
  - FSM goes to RD_WAIT_S for RD_WAIT cycles.
  - At the end of RD_WAIT_S, rsp_data_next = out_i[addr] ^ out_ref[addr].
  - FSM goes to RESP: rsp_valid=1 for one cycle with rsp_src, then returns to IDLE.
  - Responses have no backpressure. The consumer must take rsp_valid when it is asserted.
- Only one command is in flight at a time. Both readies are low outside IDLE.
- Addresses ≥ CELLS are accepted and produce no pulse. A read to such an address returns rsp_data=0.

## Timing
- Reset values: a_ready=b_ready=0, rsp_valid=0, rsp_src=0, rsp_data=0, set_o=0, reset_o=0, err_o=0, FSM=IDLE, last_grant=B.
- Let T be the handshake cycle.
- Write:
  - set_o toggles at the clock edge ending T, so the new level is visible in T+1.
  - Ready is reasserted in T+1+GAP.
- Read:
  - reset_o toggles and is visible in T+1.
  - out_i is sampled at the edge ending T+RD_WAIT.
  - rsp_valid is high in cycle T+1+RD_WAIT.
  - Ready is reasserted in T+2+RD_WAIT.
- Back-to-back commands to the same cell are therefore separated by at least GAP+1 cycles (write) or RD_WAIT+2 cycles (read).
- Reset asserted mid-operation:
  - All registers, including toggle lines, return to their reset values immediately. This may itself toggle a line.
  - Any in-flight command is dropped and no response is issued.
  - The DRO bank must be re-initialised by the harness after reset.

## Configuration
- DRO_SEQ_SHADOW_CHECK_EN defined:
  - A shadow[CELLS] register is kept, reset to 0. A write sets the bit and a read clears it.
  - err_o is set, and stays set until reset, on any of:
    - a read whose rsp_data differs from shadow[addr];
    - any out_i toggle seen while in IDLE (a stray pulse, detected when out_i differs from out_ref).
- DRO_SEQ_SHADOW_CHECK_EN undefined: no shadow register is built and err_o is tied to 0.

## Test plan
- A write addr 1, then A read addr 1, with the model toggling out_i[1] 1 cycle after reset_o[1] → set_o[1] toggles in T+1, ready is low for GAP=2 cycles, then rsp_valid=1, rsp_src=0, rsp_data=1 in cycle T+4 of the read.
- A read addr 2 with no prior write → reset_o[2] toggles, rsp_data=0. With the macro defined, err_o stays 0.
- a_valid and b_valid held high for 4 commands → grants alternate A, B, A, B, with A granted first after reset.
- Macro defined, out_i[0] toggled while idle → err_o=1 on the next cycle and stays 1 until reset.
- Reset asserted during RD_WAIT_S → outputs return to 0 asynchronously, no rsp_valid is issued, and the next command is accepted in the first cycle after reset release.
